// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the multi-cycle LEGv8 control unit: opcodes, FSM states,
// mux-select encodings and the decoded instruction class.
package legv8_ctrl_pkg;

    // Opcode fields, left-aligned at instruction[31]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_R   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_MEM = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_PASS_B = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;

    // One-hot instruction class produced by the opcode decoder
    typedef struct packed {
        logic r;
        logic addi;
        logic ldur;
        logic stur;
        logic cbz;
        logic b;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode classifier: instruction[31:21] -> one-hot instruction class.
module legv8_opcode_decode
    import legv8_ctrl_pkg::*;
#(
    parameter int ENABLE_ADDI = 1
) (
    input  logic [10:0]  opcode,
    output instr_class_t cls
);

    // Match each opcode field at its own width; anything unmatched is illegal
    always_comb begin
        cls      = '0;
        cls.r    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_ORR);
        cls.addi = (ENABLE_ADDI != 0) && (opcode[10:1] == OP_ADDI);
        cls.ldur = (opcode == OP_LDUR);
        cls.stur = (opcode == OP_STUR);
        cls.cbz  = (opcode[10:3] == OP_CBZ);
        cls.b    = (opcode[10:5] == OP_B);
        cls.illegal = !(cls.r || cls.addi || cls.ldur || cls.stur || cls.cbz || cls.b);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps illegal opcodes and memory timeouts into FAULT.
module multicycle_control_unit
    import legv8_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ENABLE_ADDI  = 1,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        PC_WRITE,
    output logic        IR_WRITE,
    output logic        REG2LOC,
    output logic        ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [1:0]  ALU_OP,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        MEM2REG,
    output logic        REG_WRITE,
    output logic [1:0]  PC_SRC,
    output logic        instr_done,
    output logic        fault
);

    // Counter only needs to reach MEM_TIMEOUT-1
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_t             state, state_nxt;
    instr_class_t       cls;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               mem_state;
    logic               timeout_hit;
    logic               unused_ins;

    // Only the opcode field steers control; operand fields go to the datapath
    assign unused_ins = ^instruction[20:0];

    legv8_opcode_decode #(.ENABLE_ADDI(ENABLE_ADDI)) u_dec (
        .opcode (instruction[31:21]),
        .cls    (cls)
    );

    assign mem_state   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Last allowed wait cycle; a mem_ready in this same cycle still completes
    assign timeout_hit = (MEM_TIMEOUT != 0) && (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // State register; reset abandons any in-flight instruction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Wait counter: cleared on every state change, counts stalled memory cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         tmo_cnt <= '0;
        else if (state_nxt != state)       tmo_cnt <= '0;
        else if (mem_state && !mem_ready)  tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Next-state and Moore outputs; FETCH/BRANCH PC and IR loads are input-qualified
    always_comb begin
        state_nxt  = state;
        PC_WRITE   = 1'b0;
        IR_WRITE   = 1'b0;
        REG2LOC    = 1'b0;
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = SRCB_REG;
        ALU_OP     = ALU_ADD;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        MEM2REG    = 1'b0;
        REG_WRITE  = 1'b0;
        PC_SRC     = PCSRC_ALU;
        instr_done = 1'b0;
        fault      = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                MEM_READ  = 1'b1;
                ALU_SRC_B = SRCB_FOUR;
                if (mem_ready) begin
                    IR_WRITE  = 1'b1;
                    PC_WRITE  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                // PC + (imm << 2) lands in the branch-target register
                ALU_SRC_B = SRCB_IMM_SH2;
                if (cls.r)         state_nxt = S_EXEC_R;
                else if (cls.addi) state_nxt = S_EXEC_I;
                else if (cls.ldur || cls.stur) state_nxt = S_ADDR;
                else if (cls.cbz)  state_nxt = S_BRANCH;
                else if (cls.b)    state_nxt = S_JUMP;
                else if (TRAP_ILLEGAL != 0) state_nxt = S_FAULT;
                else begin
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ALU_SRC_A = 1'b1;
                ALU_OP    = ALU_FUNCT;
                state_nxt = S_WB_R;
            end
            S_EXEC_I: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = SRCB_IMM;
                state_nxt = S_WB_R;
            end
            S_WB_R: begin
                REG_WRITE  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ADDR: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = SRCB_IMM;
                REG2LOC   = cls.stur;
                state_nxt = cls.stur ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MEM_READ = 1'b1;
                if (mem_ready)        state_nxt = S_WB_MEM;
                else if (timeout_hit) state_nxt = S_FAULT;
            end
            S_WB_MEM: begin
                REG_WRITE  = 1'b1;
                MEM2REG    = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_WR: begin
                MEM_WRITE = 1'b1;
                REG2LOC   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end else if (timeout_hit) begin
                    state_nxt = S_FAULT;
                end
            end
            S_BRANCH: begin
                REG2LOC    = 1'b1;
                ALU_SRC_A  = 1'b1;
                ALU_OP     = ALU_PASS_B;
                PC_SRC     = PCSRC_TARGET;
                PC_WRITE   = zero;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JUMP: begin
                PC_SRC     = PCSRC_TARGET;
                PC_WRITE   = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit. Two instances with different
// parameter sets each run their own pre-built cycle trace: every trace entry
// holds the inputs for one cycle and the output vector that cycle must show.
module tb_multicycle_control_unit;

    localparam int C_R = 0, C_ADDI = 1, C_LDUR = 2, C_STUR = 3, C_CBZ = 4, C_B = 5, C_ILL = 6;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        logic        zero;
        logic [15:0] exp;
        logic        has_pin;
        logic [15:0] pin;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i [2];
    logic [31:0] ins_i [2];
    logic        rdy_i [2];
    logic        zero_i [2];
    logic        pcw [2], irw [2], r2l [2], srca [2], memr [2], memw [2];
    logic        m2r [2], regw [2], done [2], flt [2];
    logic [1:0]  srcb [2], aluop [2], pcsrc [2];
    logic [15:0] out_v [2];

    cyc_t q0[$], q1[$];
    cyc_t cur [2];
    logic run = 1'b0;
    int   step = 0;
    int   n_cmp = 0, n_bad = 0;

    // trace-builder context for the instruction being generated
    logic [31:0] cur_ins;
    logic        cur_zero;
    int          cut;
    logic        cut_done;

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign out_v[g] = {pcw[g], irw[g], r2l[g], srca[g], srcb[g], aluop[g],
                           memr[g], memw[g], m2r[g], regw[g], pcsrc[g], done[g], flt[g]};
    end

    multicycle_control_unit #(.MEM_TIMEOUT(16), .ENABLE_ADDI(1), .TRAP_ILLEGAL(1)) u0 (
        .clk(clk), .reset(rst_i[0]), .instruction(ins_i[0]), .mem_ready(rdy_i[0]), .zero(zero_i[0]),
        .PC_WRITE(pcw[0]), .IR_WRITE(irw[0]), .REG2LOC(r2l[0]), .ALU_SRC_A(srca[0]),
        .ALU_SRC_B(srcb[0]), .ALU_OP(aluop[0]), .MEM_READ(memr[0]), .MEM_WRITE(memw[0]),
        .MEM2REG(m2r[0]), .REG_WRITE(regw[0]), .PC_SRC(pcsrc[0]), .instr_done(done[0]), .fault(flt[0])
    );

    multicycle_control_unit #(.MEM_TIMEOUT(0), .ENABLE_ADDI(0), .TRAP_ILLEGAL(0)) u1 (
        .clk(clk), .reset(rst_i[1]), .instruction(ins_i[1]), .mem_ready(rdy_i[1]), .zero(zero_i[1]),
        .PC_WRITE(pcw[1]), .IR_WRITE(irw[1]), .REG2LOC(r2l[1]), .ALU_SRC_A(srca[1]),
        .ALU_SRC_B(srcb[1]), .ALU_OP(aluop[1]), .MEM_READ(memr[1]), .MEM_WRITE(memw[1]),
        .MEM2REG(m2r[1]), .REG_WRITE(regw[1]), .PC_SRC(pcsrc[1]), .instr_done(done[1]), .fault(flt[1])
    );

    function automatic logic [15:0] v(input logic pcw_, input logic irw_, input logic r2l_,
                                      input logic a_, input logic [1:0] b_, input logic [1:0] op_,
                                      input logic mr_, input logic mw_, input logic m2r_,
                                      input logic rw_, input logic [1:0] pcs_, input logic dn_,
                                      input logic fl_);
        return {pcw_, irw_, r2l_, a_, b_, op_, mr_, mw_, m2r_, rw_, pcs_, dn_, fl_};
    endfunction

    function automatic logic [31:0] mk_ins(input int cls);
        logic [10:0] rops [4];
        logic [31:0] r;
        rops = '{11'h458, 11'h658, 11'h450, 11'h550};
        r = $urandom;
        case (cls)
            C_R:    return {rops[$urandom_range(0, 3)], r[20:0]};
            C_ADDI: return {10'h244, r[21:0]};
            C_LDUR: return {11'h7C2, r[20:0]};
            C_STUR: return {11'h7C0, r[20:0]};
            C_CBZ:  return {8'hB4, r[23:0]};
            C_B:    return {6'h05, r[25:0]};
            default: return {2'b01, r[29:0]};
        endcase
    endfunction

    function automatic int rwait();
        if ($urandom_range(0, 4) != 0) return int'($urandom_range(0, 3));
        return int'($urandom_range(13, 18));
    endfunction

    task automatic push(input int k, input logic r, input logic rdy, input logic [15:0] e);
        cyc_t c;
        c.rst = r; c.ins = cur_ins; c.rdy = rdy; c.zero = cur_zero;
        c.exp = e; c.has_pin = 1'b0; c.pin = 16'h0;
        if (k == 0) q0.push_back(c);
        else        q1.push_back(c);
    endtask

    // reset cycle, then one idle cycle: both must show all-zero outputs
    task automatic push_reset(input int k);
        push(k, 1'b1, 1'($urandom), 16'h0000);
        push(k, 1'b0, 1'($urandom), 16'h0000);
    endtask

    task automatic emit(input int k, input logic rdy, input logic [15:0] e);
        if (cut_done) return;
        if (cut == 0) begin
            push_reset(k);
            cut_done = 1'b1;
            return;
        end
        if (cut > 0) cut--;
        push(k, 1'b0, rdy, e);
    endtask

    task automatic pin(input int k, input int back, input logic [15:0] val);
        cyc_t c;
        int   idx;
        idx = ((k == 0) ? q0.size() : q1.size()) - 1 - back;
        c = (k == 0) ? q0[idx] : q1[idx];
        c.has_pin = 1'b1;
        c.pin = val;
        if (k == 0) q0[idx] = c;
        else        q1[idx] = c;
    endtask

    // FAULT is sticky: a few cycles of fault=1, then reset recovers it
    task automatic fault_tail(input int k);
        for (int i = 0; i < 3; i++) emit(k, 1'($urandom), v(0,0,0,0,2'b00,2'b00,0,0,0,0,2'b00,0,1));
        if (!cut_done) push_reset(k);
        cut_done = 1'b1;
    endtask

    // w stalled cycles then the accepting cycle, or a timeout into FAULT
    task automatic wait_phase(input int k, input int w, input logic [15:0] vw, input logic [15:0] va);
        int t;
        t = (k == 0) ? 16 : 0;
        if (t != 0 && w >= t) begin
            for (int i = 0; i < t; i++) emit(k, 1'b0, vw);
            fault_tail(k);
        end else begin
            for (int i = 0; i < w; i++) emit(k, 1'b0, vw);
            emit(k, 1'b1, va);
        end
    endtask

    task automatic gen(input int k, input int cls_in, input logic [31:0] ins, input logic z,
                       input int wf, input int wm, input int cut_at);
        int cls;
        cls = (k == 1 && cls_in == C_ADDI) ? C_ILL : cls_in;
        cur_ins = ins; cur_zero = z; cut = cut_at; cut_done = 1'b0;
        wait_phase(k, wf, v(0,0,0,0,2'b01,2'b00,1,0,0,0,2'b00,0,0),
                          v(1,1,0,0,2'b01,2'b00,1,0,0,0,2'b00,0,0));
        if (cls == C_ILL) begin
            if (k == 0) begin
                emit(k, 1'($urandom), v(0,0,0,0,2'b11,2'b00,0,0,0,0,2'b00,0,0));
                fault_tail(k);
            end else begin
                emit(k, 1'($urandom), v(0,0,0,0,2'b11,2'b00,0,0,0,0,2'b00,1,0));
            end
            return;
        end
        emit(k, 1'($urandom), v(0,0,0,0,2'b11,2'b00,0,0,0,0,2'b00,0,0));
        case (cls)
            C_R, C_ADDI: begin
                if (cls == C_R) emit(k, 1'($urandom), v(0,0,0,1,2'b00,2'b10,0,0,0,0,2'b00,0,0));
                else            emit(k, 1'($urandom), v(0,0,0,1,2'b10,2'b00,0,0,0,0,2'b00,0,0));
                emit(k, 1'($urandom), v(0,0,0,0,2'b00,2'b00,0,0,0,1,2'b00,1,0));
            end
            C_LDUR: begin
                emit(k, 1'($urandom), v(0,0,0,1,2'b10,2'b00,0,0,0,0,2'b00,0,0));
                wait_phase(k, wm, v(0,0,0,0,2'b00,2'b00,1,0,0,0,2'b00,0,0),
                                  v(0,0,0,0,2'b00,2'b00,1,0,0,0,2'b00,0,0));
                emit(k, 1'($urandom), v(0,0,0,0,2'b00,2'b00,0,0,1,1,2'b00,1,0));
            end
            C_STUR: begin
                emit(k, 1'($urandom), v(0,0,1,1,2'b10,2'b00,0,0,0,0,2'b00,0,0));
                wait_phase(k, wm, v(0,0,1,0,2'b00,2'b00,0,1,0,0,2'b00,0,0),
                                  v(0,0,1,0,2'b00,2'b00,0,1,0,0,2'b00,1,0));
            end
            C_CBZ: emit(k, 1'($urandom), v(z,0,1,1,2'b00,2'b01,0,0,0,0,2'b01,1,0));
            default: emit(k, 1'($urandom), v(1,0,0,0,2'b00,2'b00,0,0,0,0,2'b01,1,0));
        endcase
    endtask

    // Compare both instances against their trace entry, mid-cycle
    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_v[k] !== cur[k].exp) begin
                    n_bad++;
                    $display("FAIL trace u%0d step %0d: got %h want %h", k, step, out_v[k], cur[k].exp);
                end
                if (cur[k].has_pin) begin
                    n_cmp++;
                    if (out_v[k] !== cur[k].pin) begin
                        n_bad++;
                        $display("FAIL pin u%0d step %0d: got %h want %h", k, step, out_v[k], cur[k].pin);
                    end
                end
            end
        end
    end

    initial begin
        cyc_t pad;
        int   n, cls, wf, wm, ct;
        for (int k = 0; k < 2; k++) begin
            rst_i[k] = 1'b1; ins_i[k] = '0; rdy_i[k] = 1'b0; zero_i[k] = 1'b0;
        end
        pad.rst = 1'b1; pad.ins = '0; pad.rdy = 1'b0; pad.zero = 1'b0;
        pad.exp = 16'h0; pad.has_pin = 1'b0; pad.pin = 16'h0;

        // instance 0: timeout 16, ADDI legal, illegal opcodes trap
        push_reset(0);
        pin(0, 1, 16'h0000);
        gen(0, C_R, 32'h8B030041, 1'b0, 0, 0, -1);      pin(0, 0, 16'h0012);
        gen(0, C_LDUR, 32'hF8408041, 1'b0, 0, 3, -1);   pin(0, 0, 16'h0032);
        gen(0, C_CBZ, 32'hB4000081, 1'b1, 0, 0, -1);    pin(0, 0, 16'hB106);
        gen(0, C_CBZ, 32'hB4000081, 1'b0, 0, 0, -1);    pin(0, 0, 16'h3106);
        gen(0, C_STUR, 32'hF8000041, 1'b0, 0, 5, 5);    pin(0, 1, 16'h0000);
        gen(0, C_R, 32'h8B030041, 1'b0, 16, 0, -1);     pin(0, 4, 16'h0001);
        gen(0, C_R, 32'h8B030041, 1'b0, 15, 0, -1);     pin(0, 3, 16'hC480);
        gen(0, C_ILL, 32'h00000000, 1'b0, 0, 0, -1);    pin(0, 4, 16'h0001);
        gen(0, C_ADDI, 32'h91000441, 1'b0, 0, 0, -1);   pin(0, 1, 16'h1800);

        // instance 1: no timeout, ADDI illegal, illegal opcodes retire as NOP
        push_reset(1);
        gen(1, C_ILL, 32'h00000000, 1'b0, 0, 0, -1);    pin(1, 0, 16'h0C02);
        gen(1, C_ADDI, 32'h91000441, 1'b0, 0, 0, -1);   pin(1, 0, 16'h0C02);
        gen(1, C_R, 32'h8B030041, 1'b0, 40, 0, -1);     pin(1, 3, 16'hC480);
        gen(1, C_STUR, 32'hF8000041, 1'b0, 2, 30, -1);  pin(1, 0, 16'h2042);

        for (int j = 0; j < 60; j++) begin
            for (int k = 0; k < 2; k++) begin
                cls = int'($urandom_range(0, 6));
                wf  = rwait();
                wm  = rwait();
                ct  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1;
                gen(k, cls, mk_ins(cls), 1'($urandom), wf, wm, ct);
            end
        end

        n = (q0.size() > q1.size()) ? q0.size() : q1.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cur[0] = pad;
            cur[1] = pad;
            if (i < q0.size()) cur[0] = q0[i];
            if (i < q1.size()) cur[1] = q1[i];
            for (int k = 0; k < 2; k++) begin
                rst_i[k]  = cur[k].rst;
                ins_i[k]  = cur[k].ins;
                rdy_i[k]  = cur[k].rdy;
                zero_i[k] = cur[k].zero;
            end
            step = i;
            run  = 1'b1;
        end
        @(negedge clk);
        #1;
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
